// File: rtl/mrd_col_sequencer.sv
// Column sequencer for an MRD matrix-inverse engine: sweeps j = 0..DIMENSION-1,
// runs the engine for ITER_NUM*STEP_LAT cycles per column and hands each column out.
// Optional macro MRD_SEQ_IDENTITY_INIT_EN selects an identity initial guess (M_init = ej).
module mrd_col_sequencer #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int ITER_NUM  = 2,
    parameter int STEP_LAT  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic [DIMENSION*WIDTH-1:0]     ej,
    output logic [DIMENSION*WIDTH-1:0]     M_init,
    output logic                           inv_load,
    output logic                           inv_en,
    input  logic [DIMENSION*WIDTH-1:0]     M_iter,
    output logic                           col_valid,
    input  logic                           col_ready,
    output logic [$clog2(DIMENSION)-1:0]   col_idx,
    output logic [DIMENSION*WIDTH-1:0]     col_data
);
    localparam int IW    = $clog2(DIMENSION);
    localparam int ITERS = ITER_NUM * STEP_LAT;
    // Counter reaches ITERS on the last ITER cycle, so it must be able to hold it.
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
    localparam logic [IW-1:0] J_LAST   = IW'(DIMENSION - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   j;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            handshake;

    assign accept    = en && !abort && (state == S_IDLE) && start;
    assign handshake = en && !abort && (state == S_OUT) && col_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start && !abort) state_nxt = S_LOAD;
                S_LOAD:    state_nxt = S_ITER;
                S_ITER:    if (cnt == CNT_LAST) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = S_OUT;
                S_OUT:     if (col_ready) state_nxt = (j == J_LAST) ? S_DONE : S_LOAD;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        col_valid = (state == S_OUT);
        inv_load  = en && (state == S_LOAD);
        inv_en    = en && (state == S_ITER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j        <= '0;
            cnt      <= '0;
            col_idx  <= '0;
            col_data <= '0;
        end else if (en && !abort) begin
            case (state)
                S_IDLE:    if (accept) j <= '0;
                S_LOAD:    cnt <= '0;
                S_ITER:    cnt <= cnt + CW'(1);
                S_CAPTURE: begin
                    col_data <= M_iter;
                    col_idx  <= j;
                end
                S_OUT:     if (handshake && j != J_LAST) j <= j + IW'(1);
                default:   ;
            endcase
        end
    end

    always_comb begin
        ej = '0;
        if (busy) ej[int'(j)*WIDTH +: WIDTH] = WIDTH'(1);
    end

`ifdef MRD_SEQ_IDENTITY_INIT_EN
    assign M_init = ej;
`else
    assign M_init = '0;
`endif

endmodule

// File: tb/tb_mrd_col_sequencer.sv
// Directed bench for mrd_col_sequencer: a progress-count model checked every cycle,
// plus hand-computed cycle/value expectations for the key scenarios.
module tb_mrd_col_sequencer;
    localparam int D     = 16;
    localparam int W     = 8;
    localparam int VW    = D * W;
    localparam int ITERS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              col_ready = 1'b1;
    logic [VW-1:0]     M_iter;
    logic              busy, done, inv_load, inv_en, col_valid;
    logic [VW-1:0]     ej, M_init, col_data;
    logic [3:0]        col_idx;

    logic [31:0]       cyc = 0;
    int                nchk = 0;
    int                nerr = 0;
    logic              chk_on = 1'b0;

    mrd_col_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .busy(busy), .done(done), .ej(ej), .M_init(M_init),
        .inv_load(inv_load), .inv_en(inv_en), .M_iter(M_iter),
        .col_valid(col_valid), .col_ready(col_ready),
        .col_idx(col_idx), .col_data(col_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign M_iter = {{(VW-32){1'b0}}, cyc};

    function automatic logic [VW-1:0] onehot(input int k);
        logic [VW-1:0] v;
        v = '0;
        v[k*W +: W] = W'(1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: each column is a count of enabled cycles since LOAD:
    // 0 = LOAD, 1..ITERS = ITER, ITERS+1 = CAPTURE, ITERS+2 = OUT.
    logic          m_busy = 0, m_done = 0;
    int            m_j = 0, m_p = 0, m_ci = 0;
    logic [VW-1:0] m_cd = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_j <= 0; m_p <= 0; m_ci <= 0; m_cd <= '0;
        end else if (en) begin
            if (!m_busy) begin
                if (start && !abort) begin
                    m_busy <= 1; m_j <= 0; m_p <= 0;
                end
            end else if (abort) begin
                m_busy <= 0; m_done <= 0; m_p <= 0;
            end else if (m_done) begin
                m_busy <= 0; m_done <= 0;
            end else if (m_p == ITERS + 1) begin
                m_cd <= M_iter; m_ci <= m_j; m_p <= m_p + 1;
            end else if (m_p == ITERS + 2) begin
                if (col_ready) begin
                    if (m_j == D - 1) m_done <= 1;
                    else begin
                        m_j <= m_j + 1; m_p <= 0;
                    end
                end
            end else begin
                m_p <= m_p + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic active;
            logic [VW-1:0] e_ej;
            active = m_busy && !m_done;
            e_ej   = m_busy ? onehot(m_j) : '0;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("col_valid", col_valid, active && m_p == ITERS + 2);
            chk("inv_load", inv_load, en && active && m_p == 0);
            chk("inv_en", inv_en, en && active && m_p >= 1 && m_p <= ITERS);
            chk("ej", ej, e_ej);
`ifdef MRD_SEQ_IDENTITY_INIT_EN
            chk("M_init", M_init, e_ej);
`else
            chk("M_init", M_init, '0);
`endif
            chk("col_idx", col_idx, m_ci);
            chk("col_data", col_data, m_cd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int base);
        start = 1;
        base  = cyc;
        tick();
        start = 0;
    endtask

    task automatic wait_valid_idx(input int idx, output int at);
        at = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (col_valid && col_idx == idx) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("timeout_valid", 0, 1);
    endtask

    initial begin
        int base, t;
        logic [VW-1:0] held;
        chk_on = 1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ej", ej, '0);
        rst = 0;
        tick();

        // Abort together with start in IDLE keeps the FSM idle.
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        @(negedge clk);
        chk("idle_start_abort_busy", busy, 0);

        // Full sweep, col_ready tied high.
        do_start(base);
        wait_valid_idx(0, t);
        chk("first_valid_cycle", t, base + 11);
        wait_valid_idx(2, t);
        chk("col2_valid_cycle", t, base + 33);
        chk("col2_data", col_data, base + 32);
        t = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        chk("done_cycle", t, base + 177);
        chk("done_col_idx", col_idx, 15);
        @(negedge clk);
        chk("busy_low_after_done", busy, 0);

        // Consumer stall in column 3.
        do_start(base);
        wait_valid_idx(3, t);
        held = col_data;
        col_ready = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_valid", col_valid, 1);
            chk("stall_data", col_data, held);
            chk("stall_idx", col_idx, 3);
        end
        col_ready = 1;
        @(negedge clk);
        chk("col4_load_after_hs", inv_load, 1);

        // Abort in ITER of column 7, then restart from column 0.
        wait_valid_idx(6, t);
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", col_valid, 0);
        chk("abort_done", done, 0);
        do_start(base);
        wait_valid_idx(0, t);
        chk("resume_col0_cycle", t, base + 11);

        // en low for 3 cycles during ITER of a fresh sweep.
        abort = 1;
        tick();
        abort = 0;
        do_start(base);
        repeat (3) tick();
        en = 0;
        repeat (3) begin
            @(negedge clk);
            chk("en_low_inv_en", inv_en, 0);
            tick();
        end
        en = 1;
        wait_valid_idx(0, t);
        chk("en_stall_col0_cycle", t, base + 14);

        // Reset during OUT of column 9.
        wait_valid_idx(9, t);
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", col_valid, 0);
        chk("mid_rst_data", col_data, '0);
        chk("mid_rst_idx", col_idx, 0);
        chk("mid_rst_ej", ej, '0);
        tick();
        rst = 0;
        tick();
        do_start(base);
        @(negedge clk);
        chk("post_rst_ej", ej, 1);
`ifdef MRD_SEQ_IDENTITY_INIT_EN
        chk("post_rst_M_init", M_init, 1);
`else
        chk("post_rst_M_init", M_init, 0);
`endif
        wait_valid_idx(0, t);
        chk("post_rst_col0_cycle", t, base + 11);

        abort = 1;
        tick();
        abort = 0;
        tick();
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
